// File: rtl/instr_prefetch_queue_if.sv
// Instruction-memory request/response bus between the prefetch queue (master)
// and instruction memory (slave).
interface instr_prefetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Prefetch queue between PC and IF/ID: fetches sequential words with one request
// outstanding, buffers {pc, instr} pairs and flushes on redirects.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  instr_prefetch_queue_if.master bus,
  output logic                   out_valid_o,
  output logic [31:0]            out_instr_o,
  output logic [31:0]            out_pc_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  typedef enum logic [1:0] {READY, WAIT_RSP, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q;
  logic [AW:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic [AW:0] count, count_next;
  logic        push, pop, issue;

  assign count      = wr_q - rd_q;
  assign push       = (state_q == WAIT_RSP) && bus.mem_valid && !redirect_i;
  assign pop        = (count != '0) && !stall_i && !redirect_i;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect that leaves a response still in flight must swallow that response.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      if ((state_q != READY) && !bus.mem_valid) begin
        state_d = DISCARD;
      end else begin
        state_d = READY;
      end
    end else begin
      case (state_q)
        READY:    if (issue) state_d = WAIT_RSP;
        WAIT_RSP: if (bus.mem_valid) state_d = issue ? WAIT_RSP : READY;
        DISCARD:  if (bus.mem_valid) state_d = READY;
        default:  state_d = READY;
      endcase
    end
  end

  // Space check includes the request being issued, so a later push never overflows.
  always_comb begin
    issue = 1'b0;
    if (rst_n && !redirect_i && (count_next < DepthW)) begin
      if ((state_q == READY) || ((state_q == WAIT_RSP) && bus.mem_valid)) begin
        issue = 1'b1;
      end
    end
    bus.mem_req  = issue;
    bus.mem_addr = fetch_pc_q;
  end

  always_comb begin
    rd_d       = rd_q;
    wr_d       = wr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_i) begin
      rd_d       = wr_q;
      fetch_pc_d = redirect_pc_i;
    end else begin
      if (pop) begin
        rd_d = rd_q + PtrOne;
      end
      if (push) begin
        wr_d = wr_q + PtrOne;
      end
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (issue) begin
        req_pc_q <= fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_q[AW-1:0]]    <= req_pc_q;
      instr_mem_q[wr_q[AW-1:0]] <= bus.mem_rdata;
    end
  end

  assign out_valid_o = (count != '0);
  assign out_pc_o    = pc_mem_q[rd_q[AW-1:0]];
  assign out_instr_o = instr_mem_q[rd_q[AW-1:0]];
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue: a memory responder plus a stream-level
// reference model (expected head PC, expected fetch address, occupancy).
module tb_instr_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus),
    .out_valid_o   (out_valid),
    .out_instr_o   (out_instr),
    .out_pc_o      (out_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          latMin = 1;
  int          latMax = 1;
  bit          memPending = 1'b0;
  logic [31:0] memAddr = '0;
  int          memDue = 0;
  int          reqEpoch = 0;
  bit          memValidNow = 1'b0;
  int          rspEpoch = 0;
  int          epoch = 0;
  int          modelCount = 0;
  logic [31:0] expFetch = '0;
  logic [31:0] expHead = '0;
  bit          lastReq, lastOutValid, lastValidIn;
  logic [31:0] lastAddr, lastOutPc;
  logic [31:0] popLog[$];

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  function automatic logic [31:0] popAt(input int i);
    if (popLog.size() > i) return popLog[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic resetModel();
    epoch++;
    modelCount = 0;
    expHead    = RESET_PC;
    expFetch   = RESET_PC;
  endtask

  task automatic memRespond();
    memValidNow   = memPending && (cyc >= memDue);
    bus.mem_valid = memValidNow;
    bus.mem_rdata = memValidNow ? instrOf(memAddr) : $urandom();
    if (memValidNow) begin
      memPending = 1'b0;
      rspEpoch   = reqEpoch;
    end
  endtask

  // Every fetched word belongs to a sequential stream started by reset or a redirect;
  // only responses to requests made in the current stream may reach the head.
  task automatic observeCycle();
    bit popEv, pushEv;
    lastReq      = bus.mem_req;
    lastAddr     = bus.mem_addr;
    lastOutValid = out_valid;
    lastOutPc    = out_pc;
    lastValidIn  = memValidNow;
    checkOutput("out_valid", out_valid, modelCount != 0);
    if (modelCount != 0) begin
      checkOutput("out_pc", out_pc, expHead);
      checkOutput("out_instr", out_instr, instrOf(expHead));
    end
    if (redirect) checkOutput("no_req_on_redirect", bus.mem_req, 0);
    if (bus.mem_req) begin
      checkOutput("mem_addr", bus.mem_addr, expFetch);
      checkOutput("one_outstanding", memPending, 0);
      expFetch++;
    end
    popEv  = (modelCount != 0) && !stall && !redirect;
    pushEv = memValidNow && (rspEpoch == epoch) && !redirect;
    if (popEv) begin
      popLog.push_back(expHead);
      expHead++;
    end
    if (redirect) begin
      modelCount = 0;
      expHead    = redirect_pc;
      expFetch   = redirect_pc;
      epoch++;
    end else begin
      modelCount = modelCount + int'(pushEv) - int'(popEv);
    end
    checkOutput("occupancy_le_depth", modelCount > DEPTH, 0);
    if (bus.mem_req) begin
      memPending = 1'b1;
      memAddr    = bus.mem_addr;
      memDue     = cyc + int'($urandom_range(latMax, latMin));
      reqEpoch   = epoch;
    end
  endtask

  task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    @(negedge clk);
    observeCycle();
    @(posedge clk);
    #1;
    cyc++;
    memRespond();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  nReq;
    int  gap;
    bit  found;
    bit  s, r;
    logic [31:0] rpc;

    rst_n         = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_out_pc", out_pc, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    rst_n = 1'b1;
    resetModel();

    $display("[TB] stream from reset with 1-cycle memory");
    popLog.delete();
    applyStimulus(0, 0, 0);
    checkOutput("c0_req", lastReq, 1);
    checkOutput("c0_addr", lastAddr, RESET_PC);
    applyStimulus(0, 0, 0);
    checkOutput("c1_out_valid", lastOutValid, 0);
    applyStimulus(0, 0, 0);
    checkOutput("c2_out_valid", lastOutValid, 1);
    checkOutput("c2_out_pc", lastOutPc, RESET_PC);
    nReq = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0);
      nReq += int'(lastReq);
    end
    checkOutput("stream_reqs", nReq, 8);
    checkOutput("stream_pops", popLog.size(), 9);
    checkOutput("wrap_pop2", popAt(2), 32'h0);
    checkOutput("wrap_pop3", popAt(3), 32'h1);

    $display("[TB] stall fill");
    applyStimulus(1, 1, 32'h0);
    nReq = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1, 0, 0);
      nReq += int'(lastReq);
    end
    checkOutput("fill_reqs", nReq, DEPTH);
    checkOutput("fill_req_stopped", lastReq, 0);
    checkOutput("fill_out_valid", lastOutValid, 1);
    popLog.delete();
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
    checkOutput("fill_pop0", popAt(0), 32'h0);
    checkOutput("fill_pop3", popAt(3), 32'h3);
    checkOutput("fill_resume", popAt(4), 32'h4);

    $display("[TB] redirect with response in flight");
    latMin = 3;
    latMax = 3;
    applyStimulus(0, 1, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(0, 0, 0);
      if (lastReq && (lastAddr == 32'h5)) found = 1'b1;
    end
    checkOutput("found_pc5_req", found, 1);
    applyStimulus(0, 1, 32'h40);
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 0);
      if (k == 1) checkOutput("redir_next_empty", lastOutValid, 0);
      if (lastReq) begin
        gap = k;
        break;
      end
    end
    checkOutput("redir_req_gap", gap, 3);
    checkOutput("redir_req_addr", lastAddr, 32'h40);
    popLog.delete();
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0);
    checkOutput("redir_first_pop", popAt(0), 32'h40);

    $display("[TB] redirect, stall and response together");
    latMin = 1;
    latMax = 1;
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0);
    applyStimulus(1, 1, 32'h100);
    checkOutput("simul_valid_in", lastValidIn, 1);
    applyStimulus(1, 0, 0);
    checkOutput("simul_empty", lastOutValid, 0);
    checkOutput("simul_req", lastReq, 1);
    checkOutput("simul_addr", lastAddr, 32'h100);

    $display("[TB] random stall, redirect and latency");
    latMin = 1;
    latMax = 4;
    popLog.delete();
    for (int i = 0; i < 300; i++) begin
      r   = ($urandom_range(24, 0) == 0);
      s   = ($urandom_range(2, 0) == 0);
      rpc = 32'hFFFF_FFF8 + 32'($urandom_range(15, 0));
      applyStimulus(s, r, rpc);
    end
    checkOutput("random_progress", popLog.size() > 40, 1);

    $display("[TB] reset mid-operation");
    latMin = 3;
    latMax = 3;
    applyStimulus(1, 1, 32'h200);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      applyStimulus(1, 0, 0);
      if (lastReq && (modelCount == 3)) found = 1'b1;
    end
    checkOutput("mid_found", found, 1);
    checkOutput("mid_pending", memPending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_mem_req", bus.mem_req, 0);
    resetModel();
    @(posedge clk);
    #1;
    cyc++;
    memRespond();
    @(posedge clk);
    #1;
    cyc++;
    memRespond();
    rst_n = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("late_rsp_seen", lastValidIn, 1);
    checkOutput("restart_req", lastReq, 1);
    checkOutput("restart_addr", lastAddr, RESET_PC);
    popLog.delete();
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0);
    checkOutput("restart_first_pop", popAt(0), RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Fetch-side block between the program counter and the IF/ID register of the five-stage pipeline. Issues word-address requests to the instruction memory through a req/valid handshake, buffers returned instructions with their PC in a small FIFO, and presents the head entry to IF/ID. It absorbs hazard stalls without refetching and flushes cleanly on branch/jump redirects, including dropping an in-flight memory response.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'd0: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  IF/ID not accepting (hazard unit holds IF/ID); head must not pop.
- redirect  in  1  branch taken or jump in a later stage; flush and refetch.
- redirect_pc  in  32  new fetch address; sampled when redirect=1.
- mem_req  out  1  one-cycle request strobe to instruction memory.
- mem_addr  out  32  word address; valid when mem_req=1.
- mem_valid  in  1  response strobe; exactly one per mem_req, at least 1 cycle after it.
- mem_rdata  in  32  instruction; valid when mem_valid=1.
- out_valid  out  1  head entry present.
- out_instr  out  32  head instruction.
- out_pc  out  32  PC of head instruction.

## Operation
- State: fetch_pc (32b), FIFO of {pc, instr} with rd/wr pointers of log2(DEPTH)+1 bits (wrap bit distinguishes full/empty), count = wr−rd.
- FSM states:
  - READY: no request outstanding.
  - WAIT: one request outstanding; response will be stored.
  - DISCARD: one request outstanding; response will be dropped.
- Issue condition: issue = (state==READY, or state==WAIT with mem_valid=1) and count_next + 0 < DEPTH and redirect=0. Only one request is ever outstanding.
  - On issue: mem_req=1, mem_addr=fetch_pc, fetch_pc ← fetch_pc+1 (word-addressed, wraps modulo 2^32), next state WAIT.
- Response in WAIT: push {pc_of_request, mem_rdata}. pc_of_request is latched at issue.
  - Issue cannot occur when the FIFO would overflow, so a push never hits a full FIFO.
- Response in DISCARD: data dropped; next state READY; issue in the same cycle is permitted from DISCARD→READY only on the following cycle.
- Pop: when out_valid=1 and stall=0 and redirect=0, rd advances.
  - Push and pop in the same cycle: count unchanged.
- Redirect (highest priority):
  - FIFO emptied (rd ← wr).
  - fetch_pc ← redirect_pc.
  - No mem_req this cycle.
  - A response arriving in the same cycle is dropped.
  - If a request is outstanding and its response is not arriving this cycle: state → DISCARD; otherwise state → READY.
  - Redirect while in DISCARD stays in DISCARD, and the newest redirect_pc wins.
- stall and redirect together: redirect wins.
- out_valid = (count≠0). out_instr/out_pc are driven from the head entry and read combinationally from registered storage.

## Timing
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, state=READY, pointers=0.
  - out_valid=0, mem_req=0, out_instr=0, out_pc=0 (head storage is cleared).
- Cycle 0 after rst deasserts: mem_req=1, mem_addr=RESET_PC.
- With 1-cycle memory: response in cycle 1 and is pushed; out_valid=1 in cycle 2. mem_req is asserted back-to-back every cycle while space allows. Sustained throughput is 1 instr/cycle.
- Redirect asserted in cycle N:
  - out_valid=0 in cycle N+1.
  - First request to redirect_pc in cycle N+1 if no request is outstanding; otherwise in the cycle after the dropped response.
- Space check counts the outstanding request: at most DEPTH entries plus zero pending at any time.

## Test plan
- Reset/stream: release rst, 1-cycle memory returning instr = 0xA000_0000+addr, stall=0 → out_pc 0,1,2,3… consecutive from cycle 2, one per cycle, out_instr matches.
- Stall fill: hold stall=1 for 10 cycles → exactly DEPTH (4) entries accepted, mem_req stops, no overflow. Release stall → pops PCs 0..3 in order, then fetching resumes at 4.
- Redirect with in-flight response: 3-cycle memory latency, redirect=1 with redirect_pc=0x40 one cycle after mem_req for PC 5 → PC 5 response discarded, next out_pc=0x40, no stale entry visible.
- Simultaneous events: redirect, stall and mem_valid in the same cycle → FIFO empty next cycle, response dropped, state READY, mem_addr=redirect_pc one cycle later.
- Wrap-around: RESET_PC=32'hFFFF_FFFE → out_pc sequence FFFF_FFFE, FFFF_FFFF, 0, 1. Run 3×DEPTH push/pop cycles with random stall → pointer wrap yields no loss or duplication (scoreboard).
- Reset mid-operation: assert rst asynchronously with 3 entries buffered and a request outstanding → out_valid=0 and mem_req=0 immediately. After release, the late mem_valid is ignored and fetch restarts at RESET_PC.
